// File: rtl/alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_wide_sequencer
// Purpose  : Initiator-side controller that runs 64-bit operation requests
//            on a 32-bit ALU as two 32-bit steps. The carry between the two
//            halves passes through the ALU flag register.
// Ports    : Clock, Reset (async, active-high)
//            ReqValid/ReqReady/ReqOp/ReqA/ReqB          - request channel
//            RespValid/RespReady/RespData/RespFlags/RespErr - response channel
//            AluA/AluB/AluFunSel/AluWF                   - drive to ALU
//            AluOut/AluFlags                             - return from ALU
// Revision : 1.0 - initial release
// ============================================================================
module alu_wide_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [2:0]  ReqOp,
    input  logic [63:0] ReqA,
    input  logic [63:0] ReqB,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [63:0] RespData,
    output logic [3:0]  RespFlags,
    output logic        RespErr,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic [4:0]  AluFunSel,
    output logic        AluWF,
    input  logic [31:0] AluOut,
    input  logic [3:0]  AluFlags
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_AND = 3'b001;
    localparam logic [2:0] c_OP_OR  = 3'b010;
    localparam logic [2:0] c_OP_XOR = 3'b011;
    localparam logic [2:0] c_OP_NOT = 3'b100;
    localparam logic [2:0] c_OP_LSL = 3'b101;
    localparam logic [2:0] c_OP_LSR = 3'b110;
    localparam logic [2:0] c_OP_RSV = 3'b111;

    localparam logic [4:0] c_FS_IDLE = 5'b10000;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_STEP1 = 3'd1;
    localparam logic [2:0] c_ST_STEP2 = 3'd2;
    localparam logic [2:0] c_ST_FLAG  = 3'd3;
    localparam logic [2:0] c_ST_RESP  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [2:0]  r_op;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [31:0] r_res_lo;
    logic [31:0] r_res_hi;
    logic        w_hi_first;
    logic [4:0]  w_fs_step1;
    logic [4:0]  w_fs_step2;
    logic        w_use_c;
    logic        w_use_v;

    // LSR must move bit 32 down into bit 31, so the high word runs first and
    // its shifted-out bit enters the low word as the carry.
    assign w_hi_first = (r_op == c_OP_LSR);
    assign w_use_c    = (r_op == c_OP_ADD) || (r_op == c_OP_LSL) || (r_op == c_OP_LSR);
    assign w_use_v    = (r_op == c_OP_ADD);

    // STEP1 codes never consume the incoming carry, so the ALU flag register
    // contents at request start do not matter.
    always_comb begin
        w_fs_step1 = c_FS_IDLE;
        w_fs_step2 = c_FS_IDLE;
        case (r_op)
            c_OP_ADD: begin w_fs_step1 = 5'b10100; w_fs_step2 = 5'b10101; end
            c_OP_AND: begin w_fs_step1 = 5'b10111; w_fs_step2 = 5'b10111; end
            c_OP_OR:  begin w_fs_step1 = 5'b11000; w_fs_step2 = 5'b11000; end
            c_OP_XOR: begin w_fs_step1 = 5'b11001; w_fs_step2 = 5'b11001; end
            c_OP_NOT: begin w_fs_step1 = 5'b10010; w_fs_step2 = 5'b10010; end
            c_OP_LSL: begin w_fs_step1 = 5'b11011; w_fs_step2 = 5'b11110; end
            c_OP_LSR: begin w_fs_step1 = 5'b11100; w_fs_step2 = 5'b11111; end
            default:  begin w_fs_step1 = c_FS_IDLE; w_fs_step2 = c_FS_IDLE; end
        endcase
    end

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (ReqValid) begin
                    w_next_state = (ReqOp == c_OP_RSV) ? c_ST_RESP : c_ST_STEP1;
                end
            end
            c_ST_STEP1: w_next_state = c_ST_STEP2;
            c_ST_STEP2: w_next_state = c_ST_FLAG;
            c_ST_FLAG:  w_next_state = c_ST_RESP;
            c_ST_RESP: begin
                if (RespReady) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ReqReady  = 1'b0;
        RespValid = 1'b0;
        AluA      = 32'd0;
        AluB      = 32'd0;
        AluFunSel = c_FS_IDLE;
        AluWF     = 1'b0;
        case (r_state)
            c_ST_IDLE: ReqReady = 1'b1;
            c_ST_STEP1: begin
                AluWF     = 1'b1;
                AluFunSel = w_fs_step1;
                AluA      = w_hi_first ? r_a[63:32] : r_a[31:0];
                AluB      = w_hi_first ? r_b[63:32] : r_b[31:0];
            end
            c_ST_STEP2: begin
                AluWF     = 1'b1;
                AluFunSel = w_fs_step2;
                AluA      = w_hi_first ? r_a[31:0] : r_a[63:32];
                AluB      = w_hi_first ? r_b[31:0] : r_b[63:32];
            end
            c_ST_RESP: RespValid = 1'b1;
            default: begin
                ReqReady  = 1'b0;
                RespValid = 1'b0;
            end
        endcase
    end

    // Request latch, result capture and response registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_op      <= 3'd0;
            r_a       <= 64'd0;
            r_b       <= 64'd0;
            r_res_lo  <= 32'd0;
            r_res_hi  <= 32'd0;
            RespData  <= 64'd0;
            RespFlags <= 4'd0;
            RespErr   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ReqValid) begin
                        r_op <= ReqOp;
                        r_a  <= ReqA;
                        r_b  <= ReqB;
                        if (ReqOp == c_OP_RSV) begin
                            RespData  <= 64'd0;
                            RespFlags <= 4'd0;
                            RespErr   <= 1'b1;
                        end else begin
                            RespErr   <= 1'b0;
                        end
                    end
                end
                c_ST_STEP1: begin
                    if (w_hi_first) r_res_hi <= AluOut;
                    else            r_res_lo <= AluOut;
                end
                c_ST_STEP2: begin
                    if (w_hi_first) r_res_lo <= AluOut;
                    else            r_res_hi <= AluOut;
                end
                c_ST_FLAG: begin
                    // AluFlags now hold the STEP2 result: its carry and
                    // overflow are those of the full 64-bit operation.
                    RespData  <= {r_res_hi, r_res_lo};
                    RespFlags <= {({r_res_hi, r_res_lo} == 64'd0),
                                  w_use_c & AluFlags[2],
                                  r_res_hi[31],
                                  w_use_v & AluFlags[0]};
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_wide_sequencer
// Purpose  : Self-checking bench for alu_wide_sequencer, paired with a
//            behavioural 32-bit ALU and checked against a 64-bit model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_wide_sequencer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  ReqOp;
    logic [63:0] ReqA;
    logic [63:0] ReqB;
    logic        RespValid;
    logic        RespReady;
    logic [63:0] RespData;
    logic [3:0]  RespFlags;
    logic        RespErr;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [31:0] AluOut;
    logic [3:0]  AluFlags;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    alu_wide_sequencer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqOp     (ReqOp),
        .ReqA      (ReqA),
        .ReqB      (ReqB),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .RespData  (RespData),
        .RespFlags (RespFlags),
        .RespErr   (RespErr),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluFunSel (AluFunSel),
        .AluWF     (AluWF),
        .AluOut    (AluOut),
        .AluFlags  (AluFlags)
    );

    // ---------------- behavioural 32-bit ALU (flags {Z,C,N,V}) -------------
    logic [3:0]  alu_flag_q = 4'b0101;   // no reset, arbitrary start value
    logic [32:0] alu_sum;
    logic        alu_c;
    logic        alu_v;

    always_comb begin
        alu_sum = 33'd0;
        AluOut  = AluA;
        alu_c   = alu_flag_q[2];
        alu_v   = alu_flag_q[0];
        case (AluFunSel)
            5'b10100: begin
                alu_sum = {1'b0, AluA} + {1'b0, AluB};
                AluOut = alu_sum[31:0]; alu_c = alu_sum[32];
                alu_v = (AluA[31] == AluB[31]) && (AluOut[31] != AluA[31]);
            end
            5'b10101: begin
                alu_sum = {1'b0, AluA} + {1'b0, AluB} + {32'd0, alu_flag_q[2]};
                AluOut = alu_sum[31:0]; alu_c = alu_sum[32];
                alu_v = (AluA[31] == AluB[31]) && (AluOut[31] != AluA[31]);
            end
            5'b10010: AluOut = ~AluA;
            5'b10111: AluOut = AluA & AluB;
            5'b11000: AluOut = AluA | AluB;
            5'b11001: AluOut = AluA ^ AluB;
            5'b11011: begin AluOut = {AluA[30:0], 1'b0};          alu_c = AluA[31]; end
            5'b11110: begin AluOut = {AluA[30:0], alu_flag_q[2]}; alu_c = AluA[31]; end
            5'b11100: begin AluOut = {1'b0, AluA[31:1]};          alu_c = AluA[0];  end
            5'b11111: begin AluOut = {alu_flag_q[2], AluA[31:1]}; alu_c = AluA[0];  end
            default:  AluOut = AluA;
        endcase
    end

    always @(posedge Clock) begin
        if (AluWF) alu_flag_q <= {(AluOut == 32'd0), alu_c, AluOut[31], alu_v};
    end
    assign AluFlags = alu_flag_q;

    // ---------------- checking helpers ------------------------------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 64-bit reference model written from the operation definitions
    task automatic model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] d, output logic [3:0] f, output logic e);
        logic [64:0] s;
        logic c, v;
        c = 1'b0; v = 1'b0; e = 1'b0; d = 64'd0;
        case (op)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                d = s[63:0]; c = s[64];
                v = (a[63] == b[63]) && (d[63] != a[63]);
            end
            3'd1: d = a & b;
            3'd2: d = a | b;
            3'd3: d = a ^ b;
            3'd4: d = ~a;
            3'd5: begin d = a << 1; c = a[63]; end
            3'd6: begin d = a >> 1; c = a[0];  end
            default: e = 1'b1;
        endcase
        f = e ? 4'd0 : {(d == 64'd0), c, d[63], v};
    endtask

    function automatic logic [4:0] exp_fs(input logic [2:0] op, input int step);
        case (op)
            3'd0: return (step == 1) ? 5'b10100 : 5'b10101;
            3'd1: return 5'b10111;
            3'd2: return 5'b11000;
            3'd3: return 5'b11001;
            3'd4: return 5'b10010;
            3'd5: return (step == 1) ? 5'b11011 : 5'b11110;
            3'd6: return (step == 1) ? 5'b11100 : 5'b11111;
            default: return 5'b10000;
        endcase
    endfunction

    // Issue one request, observe the ALU sequence, hold the response for
    // 'hold' cycles, then consume it.
    task automatic run_req(input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input int hold);
        logic [63:0] ed;
        logic [3:0]  ef;
        logic        ee;
        logic [4:0]  fs1, fs2;
        logic [31:0] a1;
        int          n, wf;
        model(op, a, b, ed, ef, ee);
        @(negedge Clock);
        chk("req_ready_idle", {63'd0, ReqReady}, 64'd1);
        ReqValid = 1'b1; ReqOp = op; ReqA = a; ReqB = b; RespReady = 1'b0;
        @(negedge Clock);
        ReqValid = 1'b0; ReqA = 64'd0; ReqB = 64'd0;
        n = 1; wf = 0; fs1 = 5'd0; fs2 = 5'd0; a1 = 32'd0;
        while (!RespValid && n < 20) begin
            if (n == 1) begin fs1 = AluFunSel; a1 = AluA; end
            if (n == 2) fs2 = AluFunSel;
            wf += int'(AluWF);
            @(negedge Clock);
            n++;
        end
        chk("latency", 64'(n), ee ? 64'd1 : 64'd4);
        if (!RespValid) return;
        chk("wf_cycles", 64'(wf), ee ? 64'd0 : 64'd2);
        if (!ee) begin
            chk("funsel_step1", {59'd0, fs1}, {59'd0, exp_fs(op, 1)});
            chk("funsel_step2", {59'd0, fs2}, {59'd0, exp_fs(op, 2)});
            chk("alu_a_step1", {32'd0, a1}, {32'd0, (op == 3'd6) ? a[63:32] : a[31:0]});
        end
        chk("resp_data", RespData, ed);
        chk("resp_flags", {60'd0, RespFlags}, {60'd0, ef});
        chk("resp_err", {63'd0, RespErr}, {63'd0, ee});
        chk("ready_in_resp", {63'd0, ReqReady}, 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge Clock);
            chk("hold_valid", {63'd0, RespValid}, 64'd1);
            chk("hold_data", RespData, ed);
            chk("hold_flags", {60'd0, RespFlags}, {60'd0, ef});
            chk("hold_ready", {63'd0, ReqReady}, 64'd0);
        end
        RespReady = 1'b1;
        @(negedge Clock);
        RespReady = 1'b0;
        chk("valid_after_consume", {63'd0, RespValid}, 64'd0);
        chk("ready_after_consume", {63'd0, ReqReady}, 64'd1);
    endtask

    // ---------------- directed + random sequence --------------------------
    initial begin
        Reset = 1'b1; ReqValid = 1'b0; ReqOp = 3'd0; ReqA = 64'd0; ReqB = 64'd0;
        RespReady = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("rst_req_ready", {63'd0, ReqReady}, 64'd1);
        chk("rst_resp_valid", {63'd0, RespValid}, 64'd0);
        chk("rst_resp_data", RespData, 64'd0);
        chk("rst_funsel", {59'd0, AluFunSel}, {59'd0, 5'b10000});
        chk("rst_wf", {63'd0, AluWF}, 64'd0);

        run_req(3'd0, 64'h00000000_FFFFFFFF, 64'h1, 0);
        run_req(3'd0, 64'h7FFFFFFF_FFFFFFFF, 64'h1, 0);
        run_req(3'd0, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 1);
        run_req(3'd5, 64'h80000000_80000000, 64'h0, 0);
        run_req(3'd6, 64'h00000001_00000001, 64'h0, 0);
        run_req(3'd3, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 0);
        run_req(3'd4, 64'h0, 64'h0, 0);
        run_req(3'd7, 64'hDEAD_BEEF, 64'h1234, 0);
        run_req(3'd0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211, 5);

        // Reset during STEP2: outputs must drop without a clock edge
        @(negedge Clock);
        ReqValid = 1'b1; ReqOp = 3'd0; ReqA = 64'h5; ReqB = 64'h7;
        @(negedge Clock);
        ReqValid = 1'b0;
        @(negedge Clock);
        chk("pre_rst_wf_step2", {63'd0, AluWF}, 64'd1);
        #2 Reset = 1'b1;
        #1;
        chk("midrst_resp_valid", {63'd0, RespValid}, 64'd0);
        chk("midrst_req_ready", {63'd0, ReqReady}, 64'd1);
        chk("midrst_wf", {63'd0, AluWF}, 64'd0);
        chk("midrst_funsel", {59'd0, AluFunSel}, {59'd0, 5'b10000});
        chk("midrst_alu_a", {32'd0, AluA}, 64'd0);
        chk("midrst_resp_data", RespData, 64'd0);
        chk("midrst_resp_flags", {60'd0, RespFlags}, 64'd0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            chk("postrst_no_resp", {63'd0, RespValid}, 64'd0);
            chk("postrst_ready", {63'd0, ReqReady}, 64'd1);
        end

        for (int t = 0; t < 40; t++) begin
            logic [2:0]  op;
            logic [63:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if (t % 8 == 0) b = ~a + 64'd1;
            run_req(op, a, b, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
